// File: rtl/srio_pkg.sv
// Shared SRIO definitions: FTYPE codes, doorbell info codes, FSM state type
// and the HELLO doorbell header layout used by requester and responder.
package srio_pkg;

    // HELLO FTYPE codes
    localparam logic [3:0] FTYPE_NREAD  = 4'h2;
    localparam logic [3:0] FTYPE_NWRITE = 4'h5;
    localparam logic [3:0] FTYPE_SWRITE = 4'h6;
    localparam logic [3:0] FTYPE_DOORB  = 4'hA;
    localparam logic [3:0] FTYPE_MESSG  = 4'hB;
    localparam logic [3:0] FTYPE_RESP   = 4'hD;

    // Doorbell info codes
    localparam logic [15:0] DB_SELF_REQ     = 16'h0101;
    localparam logic [15:0] DB_EP_READY     = 16'h0100;
    localparam logic [15:0] DB_EP_NOT_READY = 16'h01FF;
    localparam logic [15:0] DB_DATA_OK      = 16'h0200;
    localparam logic [15:0] DB_DATA_FAIL    = 16'h0201;

    // Requester FSM states
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND_SELF,
        ST_WAIT_SELF,
        ST_BACKOFF,
        ST_READY,
        ST_SEND_DATA,
        ST_WAIT_DATA,
        ST_ERROR
    } db_req_state_t;

    // HELLO doorbell header, MSB first (64 bits total)
    typedef struct packed {
        logic [7:0]  tid;
        logic [3:0]  ftype;
        logic [3:0]  ttype;
        logic        rsvd0;
        logic [1:0]  prio;
        logic        crf;
        logic [11:0] rsvd1;
        logic [15:0] info;
        logic [15:0] rsvd2;
    } hello_db_hdr_t;

    // Assemble a doorbell header from transaction ID and info field
    function automatic logic [63:0] hello_db_hdr(input logic [7:0]  tid,
                                                 input logic [15:0] info);
        hello_db_hdr_t h;
        h.tid   = tid;
        h.ftype = FTYPE_DOORB;
        h.ttype = 4'h0;
        h.rsvd0 = 1'b0;
        h.prio  = 2'h1;
        h.crf   = 1'b0;
        h.rsvd1 = '0;
        h.info  = info;
        h.rsvd2 = '0;
        return h;
    endfunction

    // Field extraction helpers for received headers
    function automatic logic [3:0] hello_ftype(input logic [63:0] hdr);
        return hdr[55:52];
    endfunction

    function automatic logic [15:0] hello_info(input logic [63:0] hdr);
        return hdr[31:16];
    endfunction

endpackage

// File: rtl/db_hdr_gen.sv
// Combinational HELLO doorbell header assembly from tid and info.
module db_hdr_gen
    import srio_pkg::*;
(
    input  logic [7:0]  tid,
    input  logic [15:0] info,
    output logic [63:0] hdr
);

    // Pure field packing; no state
    always_comb begin
        hdr = hello_db_hdr(tid, info);
    end

endmodule

// File: rtl/db_req.sv
// Source-side doorbell requester: self-check bring-up with retry/backoff,
// then data-integrity doorbells with echo matching and timeout.
module db_req
    import srio_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 1024,
    parameter int unsigned BACKOFF_CYC = 256,
    parameter int unsigned RETRY_MAX   = 8
) (
    input  logic        log_clk,
    input  logic        log_rst,
    input  logic [15:0] src_id,
    input  logic [15:0] des_id,
    input  logic        start_i,
    input  logic        xfer_done_i,
    input  logic        xfer_ok_i,
    output logic        treq_tvalid_o,
    input  logic        treq_tready_in,
    output logic        treq_tlast_o,
    output logic [63:0] treq_tdata_o,
    output logic [7:0]  treq_tkeep_o,
    output logic [31:0] treq_tuser_o,
    input  logic        tresp_tvalid_in,
    output logic        tresp_tready_o,
    input  logic        tresp_tlast_in,
    input  logic [63:0] tresp_tdata_in,
    input  logic [31:0] tresp_tuser_in,
    output logic        link_ready_o,
    output logic        busy_o,
    output logic        db_done_o,
    output logic        db_err_o,
    output logic [7:0]  retry_cnt_o
);

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);
    localparam logic [15:0] BO_LAST  = 16'(BACKOFF_CYC - 1);
    localparam logic [7:0]  RMAX     = 8'(RETRY_MAX);

    db_req_state_t state, state_nxt;
    logic [7:0]    tid, tid_nxt;
    logic [15:0]   timer, timer_nxt;
    logic [7:0]    retry_cnt, retry_nxt;
    logic [15:0]   data_info, data_info_nxt;
    logic          err_q, err_nxt;
    logic          link_q, link_nxt;
    logic          done_q, done_nxt;

    logic          resp_hit;
    logic [15:0]   resp_info;
    logic [15:0]   req_info;
    logic [63:0]   hdr;
    logic          timer_inc;
    logic          unused_resp;

    // Framing/user bits of the response channel carry nothing we act on
    assign unused_resp = ^{tresp_tlast_in, tresp_tuser_in,
                           tresp_tdata_in[63:56], tresp_tdata_in[51:32],
                           tresp_tdata_in[15:0]};

    assign resp_hit  = tresp_tvalid_in && (hello_ftype(tresp_tdata_in) == FTYPE_DOORB);
    assign resp_info = hello_info(tresp_tdata_in);

    // Beat content is derived only from registered state, so it stays
    // stable for as long as tvalid is held waiting for tready
    assign req_info  = (state == ST_SEND_SELF) ? DB_SELF_REQ : data_info;

    db_hdr_gen u_hdr_gen (
        .tid  (tid),
        .info (req_info),
        .hdr  (hdr)
    );

    // Registered-state decode of request channel and status outputs
    always_comb begin
        treq_tvalid_o  = (state == ST_SEND_SELF) || (state == ST_SEND_DATA);
        treq_tlast_o   = treq_tvalid_o;
        treq_tkeep_o   = treq_tvalid_o ? '1 : '0;
        treq_tdata_o   = treq_tvalid_o ? hdr : '0;
        treq_tuser_o   = treq_tvalid_o ? {src_id, des_id} : '0;
        tresp_tready_o = 1'b1;
        busy_o         = !((state == ST_IDLE) || (state == ST_READY) || (state == ST_ERROR));
        link_ready_o   = link_q;
        db_done_o      = done_q;
        db_err_o       = err_q;
        retry_cnt_o    = retry_cnt;
    end

    // Next-state and register-update logic
    always_comb begin
        state_nxt     = state;
        tid_nxt       = tid;
        retry_nxt     = retry_cnt;
        data_info_nxt = data_info;
        err_nxt       = err_q;
        link_nxt      = link_q;
        done_nxt      = 1'b0;
        timer_inc     = (state == ST_WAIT_SELF) || (state == ST_WAIT_DATA) ||
                        (state == ST_BACKOFF);
        timer_nxt     = (timer_inc && (timer != '1)) ? timer + 16'd1 : timer;

        unique case (state)
            ST_IDLE, ST_ERROR: begin
                if (start_i) begin
                    state_nxt = ST_SEND_SELF;
                    retry_nxt = '0;
                    err_nxt   = 1'b0;
                    link_nxt  = 1'b0;
                end
            end
            ST_SEND_SELF: begin
                if (treq_tready_in) begin
                    state_nxt = ST_WAIT_SELF;
                    retry_nxt = retry_cnt + 8'd1;
                    tid_nxt   = tid + 8'd1;
                    timer_nxt = '0;
                end
            end
            ST_WAIT_SELF: begin
                // A response in the expiry cycle takes priority over timeout
                if (resp_hit && (resp_info == DB_EP_READY)) begin
                    state_nxt = ST_READY;
                    link_nxt  = 1'b1;
                end else if ((resp_hit && (resp_info == DB_EP_NOT_READY)) ||
                             (timer == TMO_LAST)) begin
                    if (retry_cnt < RMAX) begin
                        state_nxt = ST_BACKOFF;
                        timer_nxt = '0;
                    end else begin
                        state_nxt = ST_ERROR;
                        err_nxt   = 1'b1;
                    end
                end
            end
            ST_BACKOFF: begin
                if (timer == BO_LAST) begin
                    state_nxt = ST_SEND_SELF;
                end
            end
            ST_READY: begin
                if (xfer_done_i) begin
                    state_nxt     = ST_SEND_DATA;
                    data_info_nxt = xfer_ok_i ? DB_DATA_OK : DB_DATA_FAIL;
                end
            end
            ST_SEND_DATA: begin
                if (treq_tready_in) begin
                    state_nxt = ST_WAIT_DATA;
                    tid_nxt   = tid + 8'd1;
                    timer_nxt = '0;
                end
            end
            ST_WAIT_DATA: begin
                if (resp_hit && (resp_info == data_info)) begin
                    state_nxt = ST_READY;
                    done_nxt  = 1'b1;
                end else if (timer == TMO_LAST) begin
                    state_nxt = ST_ERROR;
                    err_nxt   = 1'b1;
                    link_nxt  = 1'b0;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers, asynchronous active-high reset
    always_ff @(posedge log_clk or posedge log_rst) begin
        if (log_rst) begin
            state     <= ST_IDLE;
            tid       <= '0;
            timer     <= '0;
            retry_cnt <= '0;
            data_info <= '0;
            err_q     <= 1'b0;
            link_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state     <= state_nxt;
            tid       <= tid_nxt;
            timer     <= timer_nxt;
            retry_cnt <= retry_nxt;
            data_info <= data_info_nxt;
            err_q     <= err_nxt;
            link_q    <= link_nxt;
            done_q    <= done_nxt;
        end
    end

endmodule
